// File: rtl/cc_fill_unit_nway_pkg.sv
// Shared types and constants for the N-way line-fill unit.
// Holds the fill FSM state encoding, AXI response codes, victim LFSR constants
// and helpers deriving beat count, tag width and way-index width from parameters.
package cc_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DROP  = 2'd2,
        WRITE = 2'd3
    } fill_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    // Both SLVERR and DECERR carry bit 1, so that bit alone flags an error.
    localparam int         RESP_ERR_BIT = 1;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int beats_f(input int data_w, input int line_bytes);
        return (line_bytes * 8) / data_w;
    endfunction

    function automatic int tag_w_f(input int addr_w, input int index_w, input int line_bytes);
        return addr_w - index_w - $clog2(line_bytes);
    endfunction

    function automatic int way_w_f(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/cc_fill_unit_nway_if.sv
// Bundle of R-channel, miss-FIFO and SRAM-write signals of the fill unit.
// master: the fill unit side; slave: memory / FIFO / SRAM environment side.
// Widths follow the same parameters as the fill unit it connects to.
interface cc_fill_if
    import cc_fill_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int INDEX_W    = 8,
    parameter int NUM_WAYS   = 2
);
    localparam int TAG_W = tag_w_f(ADDR_W, INDEX_W, LINE_BYTES);
    localparam int WAY_W = way_w_f(NUM_WAYS);

    logic [DATA_W-1:0]       mem_rdata_i;
    logic [1:0]              mem_rresp_i;
    logic                    mem_rlast_i;
    logic                    mem_rvalid_i;
    logic                    mem_rready_o;
    logic                    miss_addr_fifo_empty_i;
    logic [ADDR_W-1:0]       miss_addr_fifo_rdata_i;
    logic                    miss_addr_fifo_rden_o;
    logic                    wren_o;
    logic                    wready_i;
    logic [WAY_W-1:0]        wway_o;
    logic [INDEX_W-1:0]      waddr_o;
    logic [TAG_W:0]          wdata_tag_o;
    logic [LINE_BYTES*8-1:0] wdata_data_o;
    logic                    fill_err_o;

    modport master (
        input  mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
        input  miss_addr_fifo_empty_i, miss_addr_fifo_rdata_i, wready_i,
        output mem_rready_o, miss_addr_fifo_rden_o, wren_o, wway_o,
        output waddr_o, wdata_tag_o, wdata_data_o, fill_err_o
    );

    modport slave (
        output mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
        output miss_addr_fifo_empty_i, miss_addr_fifo_rdata_i, wready_i,
        input  mem_rready_o, miss_addr_fifo_rden_o, wren_o, wway_o,
        input  waddr_o, wdata_tag_o, wdata_data_o, fill_err_o
    );

endinterface

// File: rtl/cc_fill_unit_nway_lfsr.sv
// Victim-way selector: 8-bit Fibonacci LFSR, way taken from its low bits.
// Ports: clk, rst (sync, active high), advance_i (step once), way_o (victim way).
// Latency: way_o changes the cycle after advance_i; no backpressure of its own.
module cc_way_lfsr
    import cc_fill_pkg::*;
#(
    parameter int NUM_WAYS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          advance_i,
    output logic [way_w_f(NUM_WAYS)-1:0]  way_o
);
    localparam int WAY_W = way_w_f(NUM_WAYS);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // A direct-mapped cache has only way 0.
    assign way_o = (NUM_WAYS > 1) ? lfsr_q[WAY_W-1:0] : '0;

endmodule

// File: rtl/cc_fill_unit_nway.sv
// Line-fill unit: gathers a critical-word-first R burst into a line, writes tag+line to an N-way SRAM.
// Ports: clk/rst plus bus (R channel in, miss-FIFO head/pop, SRAM write request/ready, fill error pulse).
// Latency: write request one cycle after the last beat; R is back-pressured (rready=0) while a write stalls.
module cc_fill_unit_nway
    import cc_fill_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int INDEX_W    = 8,
    parameter int NUM_WAYS   = 2
) (
    input logic       clk,
    input logic       rst,
    cc_fill_if.master bus
);
    localparam int BEATS = beats_f(DATA_W, LINE_BYTES);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = tag_w_f(ADDR_W, INDEX_W, LINE_BYTES);
    localparam int WAY_W = way_w_f(NUM_WAYS);
    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_CNT = BW'(BEATS - 1);

    fill_state_e state_q, state_d;

    logic [BW-1:0]                 cnt_q, base_q;
    logic                          err_q;
    logic [BEATS-1:0][DATA_W-1:0]  line_q;
    logic [TAG_W-1:0]              tag_q;
    logic [INDEX_W-1:0]            idx_q;

    logic [BW-1:0]    head_base, cnt_cur, base_cur, wsel;
    logic             in_idle, err_now, at_last;
    logic             rready, rhs, fill_bad, in_write, commit;
    logic [WAY_W-1:0] way;

    // Only offset bits above the beat size and the error bit of rresp matter.
    logic unused_bits;
    assign unused_bits = ^{bus.miss_addr_fifo_rdata_i, bus.mem_rresp_i[0]};

    if (BEATS > 1) begin : g_base
        assign head_base = bus.miss_addr_fifo_rdata_i[LSB +: BW];
    end else begin : g_base_one
        assign head_base = '0;
    end

    // In IDLE the first beat is consumed straight off the FIFO head, so count,
    // base and error history are taken as fresh rather than from the registers.
    always_comb begin
        in_idle  = (state_q == IDLE);
        cnt_cur  = in_idle ? '0 : cnt_q;
        base_cur = in_idle ? head_base : base_q;
        wsel     = base_cur + cnt_cur;   // BEATS is a power of 2: truncation is the wrap
        err_now  = (~in_idle & err_q) | bus.mem_rresp_i[RESP_ERR_BIT];
        at_last  = (cnt_cur == LAST_CNT);
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FILL: begin
                if (rhs) begin
                    if (bus.mem_rlast_i) begin
                        state_d = (at_last && !err_now) ? WRITE : IDLE;
                    end else begin
                        state_d = at_last ? DROP : FILL;
                    end
                end
            end
            DROP: begin
                if (rhs && bus.mem_rlast_i) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (bus.wready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        rready   = 1'b0;
        in_write = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:       rready = ~bus.miss_addr_fifo_empty_i;
                FILL, DROP: rready = 1'b1;
                WRITE:      in_write = 1'b1;
                default:    rready = 1'b0;
            endcase
        end
        rhs      = rready & bus.mem_rvalid_i;
        // Any terminating beat other than a clean last beat discards the fill.
        fill_bad = rhs & bus.mem_rlast_i & ((state_q == DROP) | ~at_last | err_now);
        commit   = in_write & bus.wready_i;

        bus.mem_rready_o          = rready;
        bus.fill_err_o            = fill_bad;
        bus.miss_addr_fifo_rden_o = fill_bad | commit;
        bus.wren_o                = in_write;
        bus.wway_o                = in_write ? way : '0;
        bus.waddr_o               = in_write ? idx_q : '0;
        bus.wdata_tag_o           = in_write ? {1'b1, tag_q} : '0;
        bus.wdata_data_o          = in_write ? line_q : '0;
    end

    // ---- Line assembly ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            line_q <= '0;
            tag_q  <= '0;
            idx_q  <= '0;
            base_q <= '0;
        end else if (rhs && state_q != DROP) begin
            line_q[wsel] <= bus.mem_rdata_i;
            cnt_q        <= cnt_cur + 1'b1;
            err_q        <= err_now;
            if (in_idle) begin
                tag_q  <= bus.miss_addr_fifo_rdata_i[ADDR_W-1 -: TAG_W];
                idx_q  <= bus.miss_addr_fifo_rdata_i[OFF_W +: INDEX_W];
                base_q <= head_base;
            end
        end
    end

    cc_way_lfsr #(
        .NUM_WAYS (NUM_WAYS)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .advance_i (commit),
        .way_o     (way)
    );

endmodule

// File: tb/tb_cc_fill_unit_nway.sv
module tb_cc_fill_unit_nway;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    cc_fill_if #(.ADDR_W(32), .DATA_W(64),  .LINE_BYTES(64), .INDEX_W(8), .NUM_WAYS(2)) b1();
    cc_fill_if #(.ADDR_W(32), .DATA_W(128), .LINE_BYTES(32), .INDEX_W(8), .NUM_WAYS(4)) b2();

    cc_fill_unit_nway #(.ADDR_W(32), .DATA_W(64), .LINE_BYTES(64), .INDEX_W(8), .NUM_WAYS(2))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    cc_fill_unit_nway #(.ADDR_W(32), .DATA_W(128), .LINE_BYTES(32), .INDEX_W(8), .NUM_WAYS(4))
        dut2 (.clk(clk), .rst(rst2), .bus(b2));

    typedef struct {
        logic [1:0]   way;
        logic [7:0]   idx;
        logic [19:0]  tag;
        logic [511:0] data;
    } exp_t;

    exp_t        sb1[$];
    exp_t        sb2[$];
    logic [31:0] fq1[$];
    logic [31:0] fq2[$];

    int checks = 0;
    int errors = 0;
    int n_wr1 = 0, n_err1 = 0, n_pop1 = 0;
    int n_wr2 = 0, n_err2 = 0, n_pop2 = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] d1(input logic [63:0] s, input int k);
        return s + 64'(k);
    endfunction

    function automatic logic [127:0] d2(input logic [63:0] s, input int k);
        return {s, s + 64'(k)};
    endfunction

    function automatic logic [511:0] line1(input int base, input logic [63:0] s);
        logic [511:0] l = '0;
        for (int k = 0; k < 8; k++) l[((base + k) % 8) * 64 +: 64] = d1(s, k);
        return l;
    endfunction

    function automatic logic [255:0] line2(input int base, input logic [63:0] s);
        logic [255:0] l = '0;
        for (int k = 0; k < 2; k++) l[((base + k) % 2) * 128 +: 128] = d2(s, k);
        return l;
    endfunction

    task automatic refresh(input bit which);
        if (!which) begin
            b1.miss_addr_fifo_empty_i = (fq1.size() == 0);
            b1.miss_addr_fifo_rdata_i = (fq1.size() != 0) ? fq1[0] : 32'h0;
        end else begin
            b2.miss_addr_fifo_empty_i = (fq2.size() == 0);
            b2.miss_addr_fifo_rdata_i = (fq2.size() != 0) ? fq2[0] : 32'h0;
        end
    endtask

    task automatic fifo_push(input bit which, input logic [31:0] a);
        if (!which) fq1.push_back(a); else fq2.push_back(a);
        refresh(which);
    endtask

    // Expected write for a fill of addr a with beat seed s, pushed with the stimulus.
    task automatic sb_push(input bit which, input logic [1:0] way, input logic [31:0] a,
                           input logic [63:0] s);
        exp_t e;
        e.way = way;
        if (!which) begin
            e.idx  = a[13:6];
            e.tag  = {1'b0, 1'b1, a[31:14]};
            e.data = line1(int'(a[5:3]), s);
            sb1.push_back(e);
        end else begin
            e.idx  = a[12:5];
            e.tag  = {1'b1, a[31:13]};
            e.data = {256'h0, line2(int'(a[4]), s)};
            sb2.push_back(e);
        end
        fifo_push(which, a);
    endtask

    task automatic drive_beat(input bit which, input logic v, input logic [63:0] s, input int k,
                              input bit err, input bit last);
        if (!which) begin
            b1.mem_rvalid_i = v;
            b1.mem_rdata_i  = d1(s, k);
            b1.mem_rresp_i  = err ? 2'b10 : 2'b00;
            b1.mem_rlast_i  = last;
        end else begin
            b2.mem_rvalid_i = v;
            b2.mem_rdata_i  = d2(s, k);
            b2.mem_rresp_i  = err ? 2'b10 : 2'b00;
            b2.mem_rlast_i  = last;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last handshake.
    task automatic burst(input bit which, input int n, input int err_k, input int last_k,
                         input logic [63:0] s, output bit last_err, output bit last_pop,
                         output int first_wait);
        int   w;
        logic rdy;
        last_err = 1'b0;
        last_pop = 1'b0;
        first_wait = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            drive_beat(which, 1'b1, s, k, (k == err_k), (k == last_k));
            #1;
            w = 0;
            rdy = which ? b2.mem_rready_o : b1.mem_rready_o;
            while (!rdy && w < 50) begin
                @(negedge clk);
                #1;
                w++;
                rdy = which ? b2.mem_rready_o : b1.mem_rready_o;
            end
            if (!rdy) chk("rready_timeout", 512'(rdy), 512'(1));
            if (k == 0) first_wait = w;
            if (k == n - 1) begin
                last_err = which ? b2.fill_err_o : b1.fill_err_o;
                last_pop = which ? b2.miss_addr_fifo_rden_o : b1.miss_addr_fifo_rden_o;
            end
            @(posedge clk);
        end
        @(negedge clk);
        drive_beat(which, 1'b0, s, 0, 1'b0, 1'b0);
    endtask

    // Waits (bounded) for wren, pops the scoreboard and compares the write fields.
    task automatic expect_write(input bit which, output int lat);
        exp_t e;
        int   w;
        logic wr;
        #1;
        w = 0;
        wr = which ? b2.wren_o : b1.wren_o;
        while (!wr && w < 20) begin
            @(negedge clk);
            #1;
            w++;
            wr = which ? b2.wren_o : b1.wren_o;
        end
        lat = w;
        chk("wren", 512'(wr), 512'(1));
        if (!which) begin
            chk("sb1_nonempty", 512'(sb1.size() != 0), 512'(1));
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                chk("w1_way",  512'(b1.wway_o),       512'(e.way));
                chk("w1_addr", 512'(b1.waddr_o),      512'(e.idx));
                chk("w1_tag",  512'(b1.wdata_tag_o),  512'(e.tag));
                chk("w1_data", b1.wdata_data_o,       e.data);
            end
        end else begin
            chk("sb2_nonempty", 512'(sb2.size() != 0), 512'(1));
            if (sb2.size() != 0) begin
                e = sb2.pop_front();
                chk("w2_way",  512'(b2.wway_o),       512'(e.way));
                chk("w2_addr", 512'(b2.waddr_o),      512'(e.idx));
                chk("w2_tag",  512'(b2.wdata_tag_o),  512'(e.tag));
                chk("w2_data", 512'(b2.wdata_data_o), e.data);
            end
        end
    endtask

    // Event monitor: samples settled outputs mid-cycle, applies FIFO pops after the edge.
    always begin
        logic p1, w1, e1, p2, w2, e2;
        @(negedge clk);
        #2;
        p1 = b1.miss_addr_fifo_rden_o; w1 = b1.wren_o & b1.wready_i; e1 = b1.fill_err_o;
        p2 = b2.miss_addr_fifo_rden_o; w2 = b2.wren_o & b2.wready_i; e2 = b2.fill_err_o;
        @(posedge clk);
        #1;
        if (p1) begin
            if (fq1.size() != 0) void'(fq1.pop_front());
            n_pop1++;
            refresh(1'b0);
        end
        if (p2) begin
            if (fq2.size() != 0) void'(fq2.pop_front());
            n_pop2++;
            refresh(1'b1);
        end
        if (w1) n_wr1++;
        if (e1) n_err1++;
        if (w2) n_wr2++;
        if (e2) n_err2++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          le, lp;
        int          fw, lat, wr0, er0, po0;
        logic [1:0]  ways2 [4];
        logic [31:0] addrs2 [4];
        ways2  = '{2'd1, 2'd2, 2'd1, 2'd2};   // lfsr[1:0] of A5, 4A, 95, 2A
        addrs2 = '{32'h0000_1230, 32'hABCD_0000, 32'h0000_0FF0, 32'h1234_5660};

        rst = 1'b1;
        rst2 = 1'b1;
        drive_beat(1'b0, 1'b0, 64'h0, 0, 1'b0, 1'b0);
        drive_beat(1'b1, 1'b0, 64'h0, 0, 1'b0, 1'b0);
        b1.wready_i = 1'b0;
        b2.wready_i = 1'b0;
        refresh(1'b0);
        refresh(1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rready", 512'(b1.mem_rready_o),          512'(0));
        chk("rst_wren",   512'(b1.wren_o),                512'(0));
        chk("rst_rden",   512'(b1.miss_addr_fifo_rden_o), 512'(0));
        chk("rst_err",    512'(b1.fill_err_o),            512'(0));
        chk("rst_wway",   512'(b1.wway_o),                512'(0));
        chk("rst_waddr",  512'(b1.waddr_o),               512'(0));
        chk("rst_tag",    512'(b1.wdata_tag_o),           512'(0));
        chk("rst_data",   b1.wdata_data_o,                512'(0));
        @(negedge clk);
        rst = 1'b0;
        rst2 = 1'b0;

        // Basic fill, wready already high: 1-cycle write, FIFO pops same cycle.
        @(negedge clk);
        b1.wready_i = 1'b1;
        sb_push(1'b0, 2'd1, 32'h0000_1E58, 64'hD000_0000_0000_0000);
        burst(1'b0, 8, -1, 7, 64'hD000_0000_0000_0000, le, lp, fw);
        chk("t1_no_err", 512'(le), 512'(0));
        expect_write(1'b0, lat);
        chk("t1_latency", 512'(lat), 512'(0));
        chk("t1_word3",   512'(b1.wdata_data_o[3*64 +: 64]), 512'(64'hD000_0000_0000_0000));
        chk("t1_word2",   512'(b1.wdata_data_o[2*64 +: 64]), 512'(64'hD000_0000_0000_0007));
        chk("t1_rready",  512'(b1.mem_rready_o),          512'(0));
        chk("t1_pop",     512'(b1.miss_addr_fifo_rden_o), 512'(1));
        @(negedge clk);
        #1;
        chk("t1_wren_off", 512'(b1.wren_o), 512'(0));
        chk("t1_npop",     512'(n_pop1),    512'(1));

        // Stalled write: wready low for 5 cycles.
        @(negedge clk);
        b1.wready_i = 1'b0;
        sb_push(1'b0, 2'd0, 32'h0000_1E58, 64'hE000_0000_0000_0100);
        burst(1'b0, 8, -1, 7, 64'hE000_0000_0000_0100, le, lp, fw);
        expect_write(1'b0, lat);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t2_wren_hold",  512'(b1.wren_o),                512'(1));
            chk("t2_waddr_hold", 512'(b1.waddr_o),               512'(8'h79));
            chk("t2_way_hold",   512'(b1.wway_o),                512'(0));
            chk("t2_word3_hold", 512'(b1.wdata_data_o[3*64 +: 64]), 512'(64'hE000_0000_0000_0100));
            chk("t2_rready_low", 512'(b1.mem_rready_o),          512'(0));
            chk("t2_no_pop",     512'(b1.miss_addr_fifo_rden_o), 512'(0));
        end
        @(negedge clk);
        b1.wready_i = 1'b1;
        #1;
        chk("t2_pop", 512'(b1.miss_addr_fifo_rden_o), 512'(1));
        @(negedge clk);
        #1;
        chk("t2_wren_off", 512'(b1.wren_o), 512'(0));
        chk("t2_npop",     512'(n_pop1),    512'(2));
        chk("t2_nwr",      512'(n_wr1),     512'(2));

        // SLVERR on beat 4: full burst accepted, error at rlast, no write.
        wr0 = n_wr1; er0 = n_err1; po0 = n_pop1;
        @(negedge clk);
        fifo_push(1'b0, 32'h0000_2040);
        burst(1'b0, 8, 4, 7, 64'h5100_0000_0000_0000, le, lp, fw);
        chk("t3_err_pulse", 512'(le), 512'(1));
        chk("t3_err_pop",   512'(lp), 512'(1));
        #1;
        chk("t3_err_1cyc",  512'(b1.fill_err_o), 512'(0));
        chk("t3_no_wren",   512'(b1.wren_o),     512'(0));
        chk("t3_nwr",  512'(n_wr1  - wr0), 512'(0));
        chk("t3_nerr", 512'(n_err1 - er0), 512'(1));
        chk("t3_npop", 512'(n_pop1 - po0), 512'(1));

        // Early rlast on beat 5.
        wr0 = n_wr1; er0 = n_err1; po0 = n_pop1;
        @(negedge clk);
        fifo_push(1'b0, 32'h0000_4000);
        burst(1'b0, 5, -1, 4, 64'h5200_0000_0000_0000, le, lp, fw);
        chk("t4_err_pulse", 512'(le), 512'(1));
        chk("t4_err_pop",   512'(lp), 512'(1));
        #1;
        chk("t4_no_wren", 512'(b1.wren_o), 512'(0));
        chk("t4_nwr",  512'(n_wr1  - wr0), 512'(0));
        chk("t4_nerr", 512'(n_err1 - er0), 512'(1));

        // 10-beat burst: overrun dropped, error only at rlast.
        wr0 = n_wr1; er0 = n_err1; po0 = n_pop1;
        @(negedge clk);
        fifo_push(1'b0, 32'h0000_8000);
        burst(1'b0, 10, -1, 9, 64'h5300_0000_0000_0000, le, lp, fw);
        chk("t5_err_pulse", 512'(le), 512'(1));
        #1;
        chk("t5_nwr",  512'(n_wr1  - wr0), 512'(0));
        chk("t5_nerr", 512'(n_err1 - er0), 512'(1));
        chk("t5_npop", 512'(n_pop1 - po0), 512'(1));

        // rvalid with empty FIFO: no handshake until an entry appears.
        @(negedge clk);
        drive_beat(1'b0, 1'b1, 64'h6000_0000_0000_0000, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_rready_empty", 512'(b1.mem_rready_o), 512'(0));
            @(negedge clk);
        end
        sb_push(1'b0, 2'd1, 32'h0000_3FF8, 64'h6000_0000_0000_0000);
        burst(1'b0, 8, -1, 7, 64'h6000_0000_0000_0000, le, lp, fw);
        chk("t6_first_wait", 512'(fw), 512'(0));
        expect_write(1'b0, lat);
        @(negedge clk);

        // Wide-beat 4-way instance: 2-beat fills, way follows lfsr[1:0].
        b2.wready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sb_push(1'b1, ways2[i], addrs2[i], 64'h7000_0000_0000_0000 + 64'(i * 16));
            burst(1'b1, 2, -1, 1, 64'h7000_0000_0000_0000 + 64'(i * 16), le, lp, fw);
            expect_write(1'b1, lat);
            chk("s_latency", 512'(lat), 512'(0));
        end
        @(negedge clk);
        #1;
        chk("s_nwr", 512'(n_wr2), 512'(4));

        // Reset mid-fill: abandoned, no pop, LFSR back to seed.
        wr0 = n_wr2; po0 = n_pop2;
        @(negedge clk);
        fifo_push(1'b1, 32'h0000_0510);
        drive_beat(1'b1, 1'b1, 64'h8000_0000_0000_0000, 0, 1'b0, 1'b0);
        #1;
        chk("r_first_beat", 512'(b2.mem_rready_o), 512'(1));
        @(negedge clk);
        drive_beat(1'b1, 1'b0, 64'h0, 0, 1'b0, 1'b0);
        rst2 = 1'b1;
        #1;
        chk("r_no_pop_in_rst", 512'(b2.miss_addr_fifo_rden_o), 512'(0));
        repeat (2) @(negedge clk);
        #1;
        chk("r_wren_in_rst", 512'(b2.wren_o), 512'(0));
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("r_fifo_kept", 512'(fq2.size()), 512'(1));
        chk("r_npop",      512'(n_pop2 - po0), 512'(0));
        chk("r_nwr",       512'(n_wr2 - wr0),  512'(0));
        void'(fq2.pop_front());
        @(negedge clk);
        sb_push(1'b1, 2'd1, 32'h0000_0510, 64'h8100_0000_0000_0000);
        burst(1'b1, 2, -1, 1, 64'h8100_0000_0000_0000, le, lp, fw);
        expect_write(1'b1, lat);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_fill_unit_nway.md
Name: cc_fill_unit_nway

Overview:
Parametrised successor to the cache-controller line-fill path. It collects a wrap-ordered (critical-word-first) AXI R burst from memory into a full cache line, using the address popped from the miss-address FIFO. It then writes tag and line into an N-way SRAM through a stallable write handshake. It also detects error and malformed bursts, and selects the victim way with an internal LFSR.

Parameters:
ADDR_W, 32, miss address width
DATA_W, 64, R-channel beat width (power of 2, at least 8)
LINE_BYTES, 64, cache line size in bytes (power of 2)
INDEX_W, 8, set index width
NUM_WAYS, 2, associativity (power of 2, at least 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_rdata_i  in  DATA_W  R-channel data
mem_rresp_i  in  2  R-channel response; bit1 set means error
mem_rlast_i  in  1  last beat of burst
mem_rvalid_i  in  1  R valid
mem_rready_o  out  1  R ready, driven by this block
miss_addr_fifo_empty_i  in  1  miss FIFO empty
miss_addr_fifo_rdata_i  in  ADDR_W  head of miss FIFO (first-word-fall-through)
miss_addr_fifo_rden_o  out  1  pop miss FIFO
wren_o  out  1  SRAM write request
wready_i  in  1  SRAM accepts write
wway_o  out  max(1,log2 NUM_WAYS)  victim way
waddr_o  out  INDEX_W  set index
wdata_tag_o  out  TAG_W+1  {valid=1, tag}
wdata_data_o  out  LINE_BYTES*8  assembled line
fill_err_o  out  1  one-cycle pulse when a fill is discarded

Behaviour:
- Derived values: BEATS = LINE_BYTES*8/DATA_W; OFF_W = log2 LINE_BYTES; TAG_W = ADDR_W-INDEX_W-OFF_W; base word = addr[OFF_W-1:log2(DATA_W/8)].
- Reset values:
  - All outputs are 0.
  - State is IDLE; beat counter, error flag and line buffer are 0.
  - LFSR is 8'hA5.
  - Reset asserted mid-fill or mid-write abandons the fill; the FIFO is not popped.
- IDLE:
  - mem_rready_o = ~miss_addr_fifo_empty_i.
  - The first R handshake latches tag/index/base from the FIFO head, stores the beat, sets cnt=1, and ORs rresp[1] into the error flag.
  - If rlast arrives on that beat and BEATS>1, the fill is an error (see below).
- FILL:
  - mem_rready_o = 1.
  - Beat k is stored at word (base+k) mod BEATS; wrap is a modulo-BEATS add.
  - On each handshake, cnt increments and rresp[1] is accumulated.
  - On rlast with cnt==BEATS-1 and no error, go to WRITE.
  - rlast at any other count, or with the error flag set, is an error.
  - A handshake with cnt==BEATS-1 and no rlast goes to DROP.
- DROP: mem_rready_o = 1; beats are discarded until rlast, which is an error.
- Error completion, same cycle as the terminating handshake:
  - fill_err_o=1 and miss_addr_fifo_rden_o=1.
  - No SRAM write; return to IDLE.
- WRITE:
  - Entered the cycle after the last beat (1-cycle latency).
  - mem_rready_o=0; wren_o=1.
  - waddr/wway/tag/data stay stable until wready_i.
  - On wren_o & wready_i: miss_addr_fifo_rden_o=1 that cycle, LFSR advances, state goes to IDLE.
  - wready_i already high on entry completes the write in 1 cycle.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. wway_o = lfsr[WAY_W-1:0]; constant 0 when NUM_WAYS=1. It advances only on a committed write.
- Back-to-back fills: IDLE may accept a new first beat the cycle after the write handshake or error completion. The FIFO head is then the next entry.
- rvalid with the FIFO empty in IDLE: no handshake; the beat waits.

Decomposition:
- Package cc_fill_pkg holds:
  - state enum (IDLE, FILL, DROP, WRITE)
  - RESP_* constants
  - LFSR seed and tap constants
  - functions for BEATS, TAG_W and WAY_W
- One sub-module, cc_way_lfsr (inputs clk, rst, advance_i; output way_o), replacing the fixed 2-way selector.

Test Plan:
- Defaults, FIFO holds 0x0000_1E58 (base word 3), 8 beats D0..D7 OKAY with rlast on beat 7 -> next cycle wren=1, waddr=0x79, tag={1,18'h0}, word3=D0, word2=D7. With wready=1 the FIFO pops that cycle and wway=lfsr[0] of 8'hA5 =1.
- Same burst with wready held low 5 cycles -> wren and outputs stable, rready=0, no pop until the wready cycle. A new rvalid is accepted only afterwards.
- SLVERR (rresp=2'b10) on beat 4 -> remaining beats accepted; at rlast fill_err_o pulses 1 cycle and the FIFO pops; wren never asserted.
- rlast on beat 5 -> error pulse and pop. 10-beat burst -> DROP, error pulse on beat 10, no write.
- FIFO empty with rvalid=1 for 3 cycles -> rready=0. FIFO becomes non-empty -> first beat accepted that cycle.
- Parameter sweep DATA_W=128/LINE_BYTES=32/NUM_WAYS=4 -> 2-beat fills, wway follows lfsr[1:0] over 4 consecutive writes. Reset asserted mid-FILL -> no write, no pop, LFSR back to 8'hA5.
